// File: rtl/blu_pkg.sv
// Shared types and constants for the bitwise logic unit.
// The beat struct is declared in the top because it depends on WIDTH.
package blu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_NOTA = 3'd7
  } op_e;

endpackage

// File: rtl/blu_logic_core.sv
// Combinational per-bit logic function plus zero / all-ones flags.
// Used once, on the load path of the output register.
module blu_logic_core
  import blu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_ANDN: result = a & ~b;
      OP_NOTA: result = ~a;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign ones = (result == '1);

endmodule

// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise logic unit: registered in_ready, one-deep skid buffer,
// registered result/flags and a wrapping count of delivered results.
module bitwise_logic_unit
  import blu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] txn_count
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
  } beat_t;

  // Handshake: a beat moves on a rising edge where valid && ready are both 1;
  // a producer holding valid keeps its beat steady until ready is seen.
  logic  accept;
  logic  xfer;
  logic  load;
  logic  avail;
  logic  skid_valid;
  beat_t skid;
  beat_t in_beat;
  beat_t src;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_ones;

  assign in_beat = '{a: in_a, b: in_b, op: op_e'(in_op)};
  assign accept  = in_valid && in_ready;
  assign xfer    = out_valid && out_ready;
  assign load    = !out_valid || out_ready;
  assign avail   = skid_valid || accept;
  // The skid holds the older beat, so it always wins over the port.
  assign src     = skid_valid ? skid : in_beat;

  blu_logic_core #(.WIDTH(WIDTH)) u_core (
    .a      (src.a),
    .b      (src.b),
    .op     (src.op),
    .result (core_result),
    .zero   (core_zero),
    .ones   (core_ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid       <= '0;
      in_ready   <= 1'b1;
    end else if (skid_valid && load) begin
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (accept && !load) begin
      skid_valid <= 1'b1;
      skid       <= in_beat;
      in_ready   <= 1'b0;
    end
  end

  // Data and flags only change when a real beat loads; a bubble keeps them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_ones  <= 1'b0;
    end else if (load) begin
      out_valid <= avail;
      if (avail) begin
        out_data <= core_result;
        out_zero <= core_zero;
        out_ones <= core_ones;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (xfer) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule
